// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ===========================================================================
// vga_timing_pkg : 640x480@60 raster constants, visible-window bounds and
//                  the shared position decode used by the timing generator.
// Revision       : 1.0
// ===========================================================================
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;

  localparam int H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
  localparam int V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

  // Counter origin is the sync leading edge, so the window sits after sync+bp.
  localparam int H_VIS_START = VGA_H_SYNC + VGA_H_BP;
  localparam int H_VIS_END   = H_VIS_START + VGA_H_ACTIVE - 1;
  localparam int V_VIS_START = VGA_V_SYNC + VGA_V_BP;
  localparam int V_VIS_END   = V_VIS_START + VGA_V_ACTIVE - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t sync_len;
    cnt_t vis_start;
    cnt_t vis_end;
  } axis_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic video_on;
    logic line_start;
    logic frame_start;
  } raster_t;

  localparam raster_t RASTER_RESET = '{
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    video_on:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  function automatic axis_t make_axis(input int sync, input int bp, input int active);
    axis_t a;
    a.sync_len  = cnt_t'(sync);
    a.vis_start = cnt_t'(sync + bp);
    a.vis_end   = cnt_t'(sync + bp + active - 1);
    return a;
  endfunction

  function automatic logic in_span(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic raster_t decode(input cnt_t h, input cnt_t v,
                                     input axis_t ha, input axis_t va);
    raster_t r;
    r          = RASTER_RESET;
    r.hsync_n  = (h >= ha.sync_len);
    r.vsync_n  = (v >= va.sync_len);
    r.video_on = in_span(h, ha.vis_start, ha.vis_end) &&
                 in_span(v, va.vis_start, va.vis_end);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ===========================================================================
// wrap_counter : modulo-N up counter with enable, look-ahead value and
//                terminal-count flag.
// Revision     : 1.0
// ===========================================================================
module wrap_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_modulus_err
      $error("wrap_counter: MODULUS out of range for WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_value;

  // Terminal-count level; callers qualify it with their own enable.
  assign wrap = (r_value == c_last);

  always_comb begin
    next_value = r_value;
    if (en) begin
      next_value = wrap ? '0 : r_value + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else begin
      r_value <= next_value;
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ===========================================================================
// vga_timing_gen : 640x480@60 raster counters, syncs, visible flag, strobes.
//                  VGA_PIXEL_DIV_EN: 50 MHz clk with internal /2 pixel tick.
// Revision       : 1.0
// ===========================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] HCounter,
  output logic [CNT_W-1:0] VCounter,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             pix_tick
);

  localparam int    c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int    c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam axis_t c_h_axis  = make_axis(H_SYNC, H_BP, H_ACTIVE);
  localparam axis_t c_v_axis  = make_axis(V_SYNC, V_BP, V_ACTIVE);

  generate
    if (c_h_total > CNT_MAX || c_v_total > CNT_MAX) begin : g_total_range_err
      $error("vga_timing_gen: H/V total exceeds counter range");
    end
  endgenerate

  logic w_pix_tick;

`ifdef VGA_PIXEL_DIV_EN
  logic r_div_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_phase <= 1'b0;
    end else begin
      r_div_phase <= ~r_div_phase;
    end
  end

  assign w_pix_tick = r_div_phase;
`else
  assign w_pix_tick = 1'b1;
`endif

  cnt_t w_h_value;
  cnt_t w_h_next;
  cnt_t w_v_value;
  cnt_t w_v_next;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_v_en;

  wrap_counter #(
    .MODULUS (c_h_total),
    .WIDTH   (CNT_W)
  ) u_hcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_pix_tick),
    .value      (w_h_value),
    .next_value (w_h_next),
    .wrap       (w_h_wrap)
  );

  assign w_v_en = w_h_wrap & w_pix_tick;

  wrap_counter #(
    .MODULUS (c_v_total),
    .WIDTH   (CNT_W)
  ) u_vcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_v_en),
    .value      (w_v_value),
    .next_value (w_v_next),
    .wrap       (w_v_wrap)
  );

  // Decode the look-ahead position so registered outputs line up with the counters.
  raster_t w_raster_next;
  raster_t r_raster;

  always_comb begin
    w_raster_next             = decode(w_h_next, w_v_next, c_h_axis, c_v_axis);
    w_raster_next.line_start  = w_h_wrap;
    w_raster_next.frame_start = w_h_wrap & w_v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raster <= RASTER_RESET;
    end else if (w_pix_tick) begin
      r_raster <= w_raster_next;
    end
  end

  assign HCounter    = w_h_value;
  assign VCounter    = w_v_value;
  assign hsync_n     = r_raster.hsync_n;
  assign vsync_n     = r_raster.vsync_n;
  assign video_on    = r_raster.video_on;
  assign line_start  = r_raster.line_start;
  assign frame_start = r_raster.frame_start;
  assign pix_tick    = w_pix_tick;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It produces the free-running `HCounter`/`VCounter` pair that every draw stage (planet, ship, asteroids) decodes for its colour outputs. It also produces the active-low sync pulses, the visible-area flag and the line/frame strobes that the colour mux and game-logic update stages consume. Counter origin is the leading edge of each sync pulse. The visible window is therefore H 144..783, V 35..514.

## Interface
Parameters:
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch

Ports:
- `clk` in 1: system clock. One clock domain. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `HCounter` out 10: horizontal position, 0..H_TOTAL-1 (799).
- `VCounter` out 10: vertical position, 0..V_TOTAL-1 (524).
- `hsync_n` out 1: horizontal sync, active-low.
- `vsync_n` out 1: vertical sync, active-low.
- `video_on` out 1: high inside the visible window.
- `line_start` out 1: one-pixel-tick strobe when HCounter==0.
- `frame_start` out 1: one-pixel-tick strobe when HCounter==0 and VCounter==0.
- `pix_tick` out 1: pixel enable; all outputs above change only on cycles where it is high.

## Operation
- Derived totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525). Both must be ≤ 1024 (10-bit), checked by an elaboration assertion.
- On each `pix_tick`:
  - HCounter increments.
  - At H_TOTAL-1, HCounter wraps to 0 and VCounter increments.
  - At V_TOTAL-1 with an H wrap, VCounter wraps to 0.
- VCounter never advances without an H wrap.
- `hsync_n` = 0 iff HCounter < H_SYNC.
- `vsync_n` = 0 iff VCounter < V_SYNC.
- `video_on` = 1 iff HCounter in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and VCounter in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- All decoded outputs are registered, computed from the next-count values, so they are exactly aligned with the counter value presented on the same cycle. No skew between counter and sync.
- `line_start` and `frame_start` are high for exactly one pix_tick period (see Configuration for length in clk cycles).
- Reset (async assert, any time, including mid-line): counters 0, `hsync_n`=1, `vsync_n`=1, `video_on`=0, strobes 0, divider phase 0.
- First `pix_tick` after release: counters go to H=1, V=0, `hsync_n`=0, `vsync_n`=0.
- Sync outputs read deasserted only while in reset and until that first tick.

## Timing
- Line period = 800 pixel ticks. Frame period = 420 000 pixel ticks.
- Output latency: 1 clk from the `pix_tick` cycle to updated outputs.
- `pix_tick` is combinational from the divider state.
- No handshake. Consumers sample on `pix_tick`.

## Configuration
- `VGA_PIXEL_DIV_EN` defined:
  - `clk` is 50 MHz.
  - An internal 1-bit divider asserts `pix_tick` every second clk, starting on the 2nd clk after reset release.
  - Outputs hold for 2 clk; strobes last 2 clk.
- Undefined:
  - `clk` is the 25 MHz pixel clock.
  - `pix_tick` is tied 1.
  - Counters advance every clk; strobes last 1 clk.

## Structure
- `vga_timing_pkg` holds the default timing constants, the derived H_TOTAL/V_TOTAL, and the visible-window bounds (H_VIS_START=144, H_VIS_END=783, V_VIS_START=35, V_VIS_END=514). Draw stages import the same bounds.
- One sub-module, `wrap_counter`: parameterised modulus, enable in, value and wrap-pulse out.
  - Instantiated twice.
  - The vertical instance's enable is the horizontal wrap ANDed with `pix_tick`.

## Test plan
- Reset release, macro undefined → after 1 clk H=1, V=0, `hsync_n`=0, `vsync_n`=0, `video_on`=0.
- Run 800 clk → H wraps 799→0, V=1, `line_start` high for one clk. `hsync_n` low for exactly 96 consecutive clk per line.
- Full frame (420 000 clk) → `frame_start` exactly once, at H=0,V=0. `vsync_n` low for 1600 clk. `video_on` high for exactly 307 200 clk.
- Boundary probe → `video_on` 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514) and at (144,515).
- Macro defined → each counter value held 2 clk, `pix_tick` toggles 0/1, frame = 840 000 clk, strobes 2 clk wide.
- Assert `rst_n` low at H=400, V=300 → all outputs take reset values asynchronously. Counting restarts from H=1, V=0 after release.
